vx_elastic_pipe: RTL
====================

VX_ELASTIC_PIPE -- requirements
Module: VX_elastic_pipe

Interface
REQ-001 SHALL provide parameter DATAW, default 1, payload width in bits.
REQ-002 SHALL provide parameter DEPTH, default 2, number of register stages; DEPTH < 1 SHALL fail a static assertion.
REQ-003 SHALL use one clock; reset is asynchronous and active-high.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous active-high reset.
REQ-006 valid_in  input  1  upstream item present.
REQ-007 ready_in  output  1  block accepts upstream item this cycle.
REQ-008 data_in  input  DATAW  upstream payload.
REQ-009 valid_out  output  1  downstream item present (last stage valid).
REQ-010 ready_out  input  1  downstream accepts item this cycle.
REQ-011 data_out  output  DATAW  downstream payload (last stage data).
REQ-012 count  output  $clog2(DEPTH+1)  number of occupied stages.

Function
REQ-013 SHALL hold per stage i (0..DEPTH-1) one valid bit and one DATAW data register; stage 0 is input side, stage DEPTH-1 drives valid_out/data_out.
REQ-014 fire_in = valid_in && ready_in; fire_out = valid_out && ready_out.
REQ-015 Stage DEPTH-1 SHALL advance when ready_out=1 or it is empty; stage i<DEPTH-1 SHALL advance when it is empty or stage i+1 advances (bubble collapse).
REQ-016 ready_in SHALL equal advance of stage 0, combinationally dependent on ready_out through the stage chain; no registered ready.
REQ-017 On a clock edge, an advancing stage i>0 SHALL load valid/data of stage i-1; advancing stage 0 SHALL load valid_in/data_in; a non-advancing stage SHALL hold.
REQ-018 Latency: item accepted into an empty pipe at edge N SHALL appear on valid_out after edge N+DEPTH-1 (DEPTH cycles from acceptance cycle to output cycle).
REQ-019 Throughput SHALL be one item per cycle when ready_out stays 1.
REQ-020 While valid_out=1 and ready_out=0, data_out SHALL stay stable until fire_out.
REQ-021 Items SHALL exit in acceptance order; none dropped or duplicated.
REQ-022 Full (count==DEPTH) with ready_out=0: ready_in SHALL be 0.
REQ-023 Full with ready_out=1: ready_in SHALL be 1; whole chain shifts, simultaneous fire_in and fire_out.
REQ-024 Empty upstream gaps SHALL be collapsed forward while downstream stalls, so a stalled pipe fills to DEPTH items.
REQ-025 count SHALL increment on fire_in only, decrement on fire_out only, hold on both or neither; never exceed DEPTH or wrap below 0.
REQ-026 valid_in=1 with ready_in=0: data_in SHALL be ignored; upstream holds it.

Reset
REQ-027 reset SHALL asynchronously clear all stage valid bits and count to 0; valid_out=0, ready_in=1 while reset deasserted and pipe empty.
REQ-028 Data registers SHALL NOT be reset; data_out is don't-care while valid_out=0.
REQ-029 Reset asserted mid-operation SHALL discard all in-flight items immediately, without waiting for a clock edge.
REQ-030 During reset ready_in SHALL be forced to 0.

Verification (DATAW=8, DEPTH=3)
REQ-031 Reset then single item 0xA5 at cycle 0, ready_out=1 -> valid_out=1, data_out=0xA5 at cycle 3; count 1 over cycles 1..3, 0 after.
REQ-032 Stream 0x01..0x10 back-to-back, ready_out=1 -> outputs 0x01..0x10 on consecutive cycles, ready_in never 0, count steady at 3.
REQ-033 ready_out=0, feed 0x11,0x22,0x33,0x44 -> first three accepted, ready_in=0 when count=3, data_out=0x11 stable; raise ready_out -> 0x11,0x22,0x33,0x44 in order.
REQ-034 Full pipe, ready_out=1, valid_in=1 with 0x55 -> same cycle fire_in and fire_out, count stays 3.
REQ-035 Input gaps (valid_in 1,0,1,0,1) with ready_out=0 -> three items compacted, count=3, no bubbles between outputs once ready_out=1.
REQ-036 Reset pulse asserted between clock edges with count=2 -> valid_out=0, count=0 immediately; no stale item emerges afterward.

Source files
------------

// File: rtl/vx_elastic_pipe.sv
// vx_elastic_pipe: a chain of DEPTH register stages with valid/ready handshaking.
// Each stage moves forward when the stage ahead of it is empty or is moving.
// Empty stages therefore close up while the output is stalled, so a stalled
// pipe still fills to DEPTH items. ready_in is combinational from ready_out;
// there is no skid buffer.

module vx_elastic_pipe #(
  parameter int DATAW = 1,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid_in,
  output logic                       ready_in,
  input  logic [DATAW-1:0]           data_in,
  output logic                       valid_out,
  input  logic                       ready_out,
  output logic [DATAW-1:0]           data_out,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNTW = $clog2(DEPTH+1);

  if (DEPTH < 1) begin : g_depth_check
    $error("vx_elastic_pipe: DEPTH must be at least 1");
  end

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;
  logic [DATAW-1:0] data_q [DEPTH];
  logic [DATAW-1:0] data_d [DEPTH];
  logic [DEPTH-1:0] full_from;
  logic [DEPTH-1:0] advance;
  logic [CNTW-1:0]  count_q;
  logic             fire_in;
  logic             fire_out;

  // Per-stage advance. A stage moves when ready_out is high or when it or some
  // stage downstream of it is empty. This is the flattened form of the rule
  // "advance if empty or if the next stage advances", and it has no
  // combinational loop through the advance vector.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    assign full_from[i] = &valid_q[DEPTH-1:i];
    assign advance[i]   = ready_out | ~full_from[i];

    if (i == 0) begin : g_head
      assign valid_d[i] = valid_in;
      assign data_d[i]  = data_in;
    end else begin : g_body
      assign valid_d[i] = valid_q[i-1];
      assign data_d[i]  = data_q[i-1];
    end

    // Payload register for this stage: it loads when the stage advances and holds otherwise.
    // NOTE: datapath registers have no reset; the valid bits alone decide whether the contents mean anything.
    always_ff @(posedge clk) begin
      if (advance[i]) begin
        data_q[i] <= data_d[i];
      end
    end
  end

  // Valid bit per stage: reset clears it asynchronously, and it follows the stage behind it when the stage advances.
  // NOTE: state is updated with non-blocking assignments, so every stage samples its predecessor's pre-edge value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (advance[i]) begin
          valid_q[i] <= valid_d[i];
        end
      end
    end
  end

  // Occupancy counter: +1 on accept only, -1 on emit only, hold otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      case ({fire_in, fire_out})
        2'b10:   count_q <= count_q + CNTW'(1);
        2'b01:   count_q <= count_q - CNTW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  assign ready_in  = advance[0] & ~reset;
  assign valid_out = valid_q[DEPTH-1];
  assign data_out  = data_q[DEPTH-1];
  assign fire_in   = valid_in & ready_in;
  assign fire_out  = valid_out & ready_out;
  assign count     = count_q;

endmodule
